// File: rtl/id_ex_reg_pkg.sv
// Shared pipeline definitions: decode control bundle layout and the
// encodings the control unit and the execute stage agree on.
package pipeline_pkg;

    // Control bundle carried from decode into execute.
    typedef struct packed {
        logic       RegWrite;
        logic [1:0] ResultSrc;
        logic       MemWrite;
        logic       Jump;
        logic       Branch;
        logic [3:0] ALUControl;
        logic       ALUSrc;
        logic       JALRInstr;
        logic [2:0] AddressingControl;
    } ctrl_t;

    // A bubble is an all-zero bundle: no register write, no store, no jump.
    localparam ctrl_t CTRL_BUBBLE = '0;

    // ALU operation encodings.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    // Result mux select encodings.
    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_MEM  = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

endpackage

// File: rtl/id_ex_reg_if.sv
// Decode-to-execute bundle. The hazard unit and decode stage drive the
// D side plus EnE/FlushE (master); the pipeline register drives the E side
// (slave). There is no valid/ready handshake here: EnE and FlushE are
// sampled on every rising edge, FlushE taking priority over EnE.
interface id_ex_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  EnE;
    logic                  FlushE;
    logic                  ValidD;
    logic                  RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, JALRInstrD;
    logic [1:0]            ResultSrcD;
    logic [3:0]            ALUControlD;
    logic [2:0]            AddressingControlD;
    logic [DATA_WIDTH-1:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
    logic [4:0]            Rs1D, Rs2D, RdD;

    logic                  ValidE;
    logic                  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JALRInstrE;
    logic [1:0]            ResultSrcE;
    logic [3:0]            ALUControlE;
    logic [2:0]            AddressingControlE;
    logic [DATA_WIDTH-1:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
    logic [4:0]            Rs1E, Rs2E, RdE;
    logic [CNT_WIDTH-1:0]  BubbleCountE;

    modport master (
        output EnE, FlushE, ValidD,
        output RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, JALRInstrD,
        output ResultSrcD, ALUControlD, AddressingControlD,
        output RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
        input  ValidE,
        input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JALRInstrE,
        input  ResultSrcE, ALUControlE, AddressingControlE,
        input  RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE,
        input  BubbleCountE
    );

    modport slave (
        input  EnE, FlushE, ValidD,
        input  RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, JALRInstrD,
        input  ResultSrcD, ALUControlD, AddressingControlD,
        input  RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
        output ValidE,
        output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JALRInstrE,
        output ResultSrcE, ALUControlE, AddressingControlE,
        output RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE,
        output BubbleCountE
    );
endinterface

// File: rtl/id_ex_reg_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Count increments until all-ones, then holds there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end
endmodule

// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register with stall (hold) and flush (bubble)
// plus a saturating count of inserted bubbles.
module id_ex_reg
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input logic     clk,
    input logic     rst_n,
    id_ex_if.slave  bus
);
    typedef struct packed {
        logic [DATA_WIDTH-1:0] rd1;
        logic [DATA_WIDTH-1:0] rd2;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] pc_plus4;
        logic [DATA_WIDTH-1:0] imm_ext;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
    } data_t;

    ctrl_t                ctrl_d, ctrl_e;
    data_t                data_d, data_e;
    logic                 valid_e;
    logic [CNT_WIDTH-1:0] bubble_count;

    // Gather the decode-side inputs into the stored bundle layouts.
    always_comb begin
        ctrl_d                   = CTRL_BUBBLE;
        ctrl_d.RegWrite          = bus.RegWriteD;
        ctrl_d.ResultSrc         = bus.ResultSrcD;
        ctrl_d.MemWrite          = bus.MemWriteD;
        ctrl_d.Jump              = bus.JumpD;
        ctrl_d.Branch            = bus.BranchD;
        ctrl_d.ALUControl        = bus.ALUControlD;
        ctrl_d.ALUSrc            = bus.ALUSrcD;
        ctrl_d.JALRInstr         = bus.JALRInstrD;
        ctrl_d.AddressingControl = bus.AddressingControlD;

        data_d                   = '0;
        data_d.rd1               = bus.RD1D;
        data_d.rd2               = bus.RD2D;
        data_d.pc                = bus.PCD;
        data_d.pc_plus4          = bus.PCPlus4D;
        data_d.imm_ext           = bus.ImmExtD;
        data_d.rs1               = bus.Rs1D;
        data_d.rs2               = bus.Rs2D;
        data_d.rd                = bus.RdD;
    end

    // Flush loads an all-zero bubble (RdE=0 so it never matches forwarding),
    // otherwise EnE loads decode, otherwise the stage holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_e  <= CTRL_BUBBLE;
            data_e  <= '0;
            valid_e <= 1'b0;
        end else if (bus.FlushE) begin
            ctrl_e  <= CTRL_BUBBLE;
            data_e  <= '0;
            valid_e <= 1'b0;
        end else if (bus.EnE) begin
            ctrl_e  <= ctrl_d;
            data_e  <= data_d;
            valid_e <= bus.ValidD;
        end
    end

    // Every flush edge counts as one bubble, whether or not the stage is stalled.
    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bus.FlushE),
        .count (bubble_count)
    );

    assign bus.RegWriteE          = ctrl_e.RegWrite;
    assign bus.ResultSrcE         = ctrl_e.ResultSrc;
    assign bus.MemWriteE          = ctrl_e.MemWrite;
    assign bus.JumpE              = ctrl_e.Jump;
    assign bus.BranchE            = ctrl_e.Branch;
    assign bus.ALUControlE        = ctrl_e.ALUControl;
    assign bus.ALUSrcE            = ctrl_e.ALUSrc;
    assign bus.JALRInstrE         = ctrl_e.JALRInstr;
    assign bus.AddressingControlE = ctrl_e.AddressingControl;
    assign bus.RD1E               = data_e.rd1;
    assign bus.RD2E               = data_e.rd2;
    assign bus.PCE                = data_e.pc;
    assign bus.PCPlus4E           = data_e.pc_plus4;
    assign bus.ImmExtE            = data_e.imm_ext;
    assign bus.Rs1E               = data_e.rs1;
    assign bus.Rs2E               = data_e.rs2;
    assign bus.RdE                = data_e.rd;
    assign bus.ValidE             = valid_e;
    assign bus.BubbleCountE       = bubble_count;
endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: the driver applies a D-side vector per edge
// and queues the expected E-side image; a negedge monitor pops and compares.
module tb_id_ex_reg;
    import pipeline_pkg::*;

    localparam int DW = 32;
    localparam int CW = 4;

    typedef struct packed {
        logic          RegWrite;
        logic [1:0]    ResultSrc;
        logic          MemWrite;
        logic          Jump;
        logic          Branch;
        logic [3:0]    ALUControl;
        logic          ALUSrc;
        logic          JALRInstr;
        logic [2:0]    AddressingControl;
        logic [DW-1:0] RD1;
        logic [DW-1:0] RD2;
        logic [DW-1:0] PC;
        logic [DW-1:0] PCPlus4;
        logic [DW-1:0] ImmExt;
        logic [4:0]    Rs1;
        logic [4:0]    Rs2;
        logic [4:0]    Rd;
        logic          Valid;
    } d_t;

    localparam int W = $bits(d_t) + CW;

    logic clk;
    logic rst_n;

    id_ex_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    id_ex_reg #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;

    // reference image of the E side
    d_t           m_img;
    logic [CW-1:0] m_cnt;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] sample_e();
        return {bus.RegWriteE, bus.ResultSrcE, bus.MemWriteE, bus.JumpE, bus.BranchE,
                bus.ALUControlE, bus.ALUSrcE, bus.JALRInstrE, bus.AddressingControlE,
                bus.RD1E, bus.RD2E, bus.PCE, bus.PCPlus4E, bus.ImmExtE,
                bus.Rs1E, bus.Rs2E, bus.RdE, bus.ValidE, bus.BubbleCountE};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_d(input d_t d);
        bus.RegWriteD          = d.RegWrite;
        bus.ResultSrcD         = d.ResultSrc;
        bus.MemWriteD          = d.MemWrite;
        bus.JumpD              = d.Jump;
        bus.BranchD            = d.Branch;
        bus.ALUControlD        = d.ALUControl;
        bus.ALUSrcD            = d.ALUSrc;
        bus.JALRInstrD         = d.JALRInstr;
        bus.AddressingControlD = d.AddressingControl;
        bus.RD1D               = d.RD1;
        bus.RD2D               = d.RD2;
        bus.PCD                = d.PC;
        bus.PCPlus4D           = d.PCPlus4;
        bus.ImmExtD            = d.ImmExt;
        bus.Rs1D               = d.Rs1;
        bus.Rs2D               = d.Rs2;
        bus.RdD                = d.Rd;
        bus.ValidD             = d.Valid;
    endtask

    // Drive one edge worth of stimulus, then queue what E must show after it.
    task automatic step(input string name, input logic en, input logic flush, input d_t d);
        bus.EnE    = en;
        bus.FlushE = flush;
        apply_d(d);
        @(posedge clk);
        #1;
        if (flush) begin
            m_img = '0;
            if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
        end else if (en) begin
            m_img = d;
        end
        exp_q.push_back({m_img, m_cnt});
        name_q.push_back(name);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            check(name_q.pop_front(), sample_e(), exp_q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    d_t d_alu, d_alu9, d_store, d_jalr, d_br, d_pre;

    initial begin
        d_alu = '0;
        d_alu.RegWrite   = 1'b1;
        d_alu.ALUControl = ALU_SUB;
        d_alu.RD1        = 32'h0000_0005;
        d_alu.Rd         = 5'd3;
        d_alu.Valid      = 1'b1;

        d_alu9 = d_alu;
        d_alu9.Rd        = 5'd9;
        d_alu9.RD1       = 32'h0000_0077;
        d_alu9.RD2       = 32'h1234_5678;

        d_store = '0;
        d_store.MemWrite          = 1'b1;
        d_store.AddressingControl = 3'b010;
        d_store.ALUSrc            = 1'b1;
        d_store.RD1               = 32'h0000_1000;
        d_store.RD2               = 32'hDEAD_BEEF;
        d_store.ImmExt            = 32'h0000_0008;
        d_store.Rd                = 5'd7;
        d_store.Valid             = 1'b1;

        d_jalr = '0;
        d_jalr.RegWrite  = 1'b1;
        d_jalr.ResultSrc = RES_PC4;
        d_jalr.Jump      = 1'b1;
        d_jalr.JALRInstr = 1'b1;
        d_jalr.ALUSrc    = 1'b1;
        d_jalr.RD1       = 32'h8000_0100;
        d_jalr.ImmExt    = 32'hFFFF_FFFC;
        d_jalr.PC        = 32'h0000_0040;
        d_jalr.PCPlus4   = 32'h0000_0044;
        d_jalr.Rs1       = 5'd1;
        d_jalr.Rd        = 5'd1;
        d_jalr.Valid     = 1'b1;

        d_br = '0;
        d_br.Branch     = 1'b1;
        d_br.ALUControl = ALU_SUB;
        d_br.RD1        = 32'hA5A5_A5A5;
        d_br.RD2        = 32'h5A5A_5A5A;
        d_br.PC         = 32'h0000_0080;
        d_br.PCPlus4    = 32'h0000_0084;
        d_br.ImmExt     = 32'hFFFF_FFF0;
        d_br.Rs1        = 5'd10;
        d_br.Rs2        = 5'd11;
        d_br.Valid      = 1'b0;

        d_pre = '0;
        d_pre.RegWrite = 1'b1;
        d_pre.RD1      = 32'h0000_0005;
        d_pre.Rd       = 5'd4;
        d_pre.Valid    = 1'b1;

        // reset with busy-looking inputs: outputs must be zero before any edge
        m_img  = '0;
        m_cnt  = '0;
        rst_n  = 1'b0;
        bus.EnE    = 1'b1;
        bus.FlushE = 1'b1;
        apply_d(d_jalr);
        #2;
        check("reset_init", sample_e(), '0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", sample_e(), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // normal load
        step("load_alu", 1'b1, 1'b0, d_alu);

        // stall three cycles while decode presents Rd=9, then release
        for (int i = 0; i < 3; i++) step("stall_hold", 1'b0, 1'b0, d_alu9);
        step("stall_release", 1'b1, 1'b0, d_alu9);

        // flush of a store, then flush while stalled
        step("flush_store", 1'b1, 1'b1, d_store);
        step("flush_stalled", 1'b0, 1'b1, d_store);

        // assorted full-width loads; a held bubble stays a bubble
        step("load_jalr", 1'b1, 1'b0, d_jalr);
        step("load_branch", 1'b1, 1'b0, d_br);
        step("load_store", 1'b1, 1'b0, d_store);
        step("flush_after_load", 1'b1, 1'b1, d_jalr);
        step("hold_bubble", 1'b0, 1'b0, d_jalr);

        // counter saturation: 20 flushes alternating EnE
        for (int i = 0; i < 20; i++) step("saturate", logic'(i[0]), 1'b1, d_alu);
        step("load_after_sat", 1'b1, 1'b0, d_jalr);

        // asynchronous reset between edges loses the in-flight instruction
        step("pre_reset_load", 1'b1, 1'b0, d_pre);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", sample_e(), '0);
        m_img = '0;
        m_cnt = '0;
        @(posedge clk);
        #1;
        check("async_reset_hold", sample_e(), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // first edge after release obeys normal priority
        step("post_reset_load", 1'b1, 1'b0, d_alu);
        step("post_reset_flush", 1'b0, 1'b1, d_br);

        bus.EnE    = 1'b0;
        bus.FlushE = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("queue_drained", W'(exp_q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
